// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU-side load/store handshake bundle.
// master = initiator (MEM stage), slave = responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ready,
    input  ack,
    input  rdata,
    input  err,
    input  busy
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ready,
    output ack,
    output rdata,
    output err,
    output busy
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with fixed wait states,
// misalignment and range faulting, registered ack/err/rdata.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WLOAD =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W =
    32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic        we_l;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] res_addr;
  logic [31:0] res_idx;
  logic        res_fault;
  logic [31:0] res_data;

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Resolve the access that is about to enter RESP;
  // with no wait states that is the request on the bus.
  always_comb begin
    res_addr  = addr_l;
    if (state == IDLE)
      res_addr = bus.addr;
    res_idx   = res_addr >> 2;
    res_fault = (res_addr[1:0] != 2'b00)
             || (res_idx >= DEPTH_W);
    res_data  = 32'd0;
    if (!res_fault)
      res_data = mem[res_idx[AW-1:0]];
  end

  // Handshake FSM with wait counter and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_l  <= 32'd0;
      wdata_l <= 32'd0;
      we_l    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            addr_l  <= bus.addr;
            wdata_l <= bus.wdata;
            we_l    <= bus.we;
            if (WAIT == 0) begin
              state   <= RESP;
              ack_q   <= 1'b1;
              err_q   <= res_fault;
              rdata_q <= res_data;
            end else begin
              state <= HOLD;
              cnt   <= WLOAD;
            end
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            ack_q   <= 1'b1;
            err_q   <= res_fault;
            rdata_q <= res_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Commit a good store on the edge leaving RESP;
  // a reset forces IDLE first, so a pending store is dropped.
  always_ff @(posedge clock) begin
    if (state == RESP && we_l && !err_q)
      mem[addr_l[AW+1:2]] <= wdata_l;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with scoreboard for
// WAIT=2 and WAIT=0 responders.
module tb_dmem_responder;

  logic clock = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder_if b2();
  dmem_responder_if b0();

  dmem_responder #(.DEPTH(1024), .WAIT(2)) u2 (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (b2.slave)
  );

  dmem_responder #(.DEPTH(1024), .WAIT(0)) u0 (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (b0.slave)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] st_addr[$];
  logic [31:0] st_exp[$];

  function automatic logic get_ready(int sel);
    return (sel == 0) ? b0.ready : b2.ready;
  endfunction

  function automatic logic get_ack(int sel);
    return (sel == 0) ? b0.ack : b2.ack;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 0) ? b0.busy : b2.busy;
  endfunction

  function automatic logic get_err(int sel);
    return (sel == 0) ? b0.err : b2.err;
  endfunction

  function automatic logic [31:0] get_rdata(int sel);
    return (sel == 0) ? b0.rdata : b2.rdata;
  endfunction

  function automatic int wt(int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  task automatic set_bus(input int sel, input logic r,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    if (sel == 0) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT", tag);
  endtask

  task automatic push_exp(input logic w, input logic e_err,
                          input logic [31:0] e_rd);
    exp_t e;
    e.err    = e_err;
    e.rdata  = e_rd;
    e.chk_rd = !w || e_err;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      timeout({tag, " unexpected ack"});
      return;
    end
    e = sb.pop_front();
    chk({tag, " err"}, 32'(get_err(sel)), 32'(e.err));
    if (e.chk_rd)
      chk({tag, " rdata"}, get_rdata(sel), e.rdata);
  endtask

  task automatic access(input int sel, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd,
                        input string tag);
    int acc_e;
    int ack_e;
    bit ok;
    @(negedge clock);
    set_bus(sel, 1'b1, w, a, d);
    push_exp(w, e_err, e_rd);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (get_ready(sel)) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      timeout({tag, " accept"});
      set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      sb.delete();
      return;
    end
    acc_e = cyc + 1;
    @(negedge clock);
    set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (get_ack(sel)) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      timeout({tag, " ack"});
      sb.delete();
      return;
    end
    ack_e = cyc;
    pop_cmp(sel, tag);
    chk({tag, " lat"}, 32'(ack_e - acc_e), 32'(wt(sel)));
    chk({tag, " busy@ack"}, 32'(get_busy(sel)), 32'd1);
    @(negedge clock);
    chk({tag, " ready after"}, 32'(get_ready(sel)), 32'd1);
  endtask

  // Loads with req held high; addr is swapped to 12 while busy.
  task automatic stream(input int sel, input string tag);
    int n_acc;
    int n_ack;
    int prev;
    int acc_e[$];
    n_acc = 0;
    n_ack = 0;
    prev  = -1;
    @(negedge clock);
    for (int c = 0; c < 100 && n_ack < st_addr.size(); c++) begin
      if (get_ack(sel)) begin
        pop_cmp(sel, tag);
        if (acc_e.size() > 0)
          chk({tag, " lat"}, 32'(cyc - acc_e.pop_front()),
              32'(wt(sel)));
        n_ack++;
      end
      if (n_acc < st_addr.size()) begin
        if (get_ready(sel)) begin
          set_bus(sel, 1'b1, 1'b0, st_addr[n_acc], 32'd0);
          push_exp(1'b0, 1'b0, st_exp[n_acc]);
          acc_e.push_back(cyc + 1);
          if (prev >= 0)
            chk({tag, " spacing"}, 32'(cyc + 1 - prev),
                32'(wt(sel) + 2));
          prev = cyc + 1;
          n_acc++;
        end else begin
          set_bus(sel, 1'b1, 1'b0, 32'h0000_000C, 32'd0);
        end
      end else begin
        set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      @(negedge clock);
    end
    set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    if (n_ack < st_addr.size()) begin
      timeout({tag, " stream"});
      sb.delete();
    end
    st_addr.delete();
    st_exp.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_bus(2, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("rst ready", 32'(b2.ready), 32'd1);
    chk("rst ack", 32'(b2.ack), 32'd0);
    chk("rst busy", 32'(b2.busy), 32'd0);
    chk("rst err", 32'(b2.err), 32'd0);
    chk("rst rdata", b2.rdata, 32'd0);
    chk("rst ready w0", 32'(b0.ready), 32'd1);
    rst_n = 1'b1;

    access(2, 1, 32'd0, 32'd5, 0, 32'd0, "st 5@0");
    access(2, 1, 32'd4, 32'd7, 0, 32'd0, "st 7@4");
    access(2, 0, 32'd0, 32'd0, 0, 32'd5, "ld 0");
    access(2, 0, 32'd4, 32'd0, 0, 32'd7, "ld 4");

    access(2, 1, 32'd0, 32'd7, 0, 32'd0, "sw st 7@0");
    access(2, 1, 32'd4, 32'd5, 0, 32'd0, "sw st 5@4");
    access(2, 0, 32'd0, 32'd0, 0, 32'd7, "sw ld 0");
    access(2, 0, 32'd4, 32'd0, 0, 32'd5, "sw ld 4");
    access(2, 1, 32'd0, 32'd5, 0, 32'd0, "sw st 5@0");
    access(2, 1, 32'd4, 32'd7, 0, 32'd0, "sw st 7@4");
    access(2, 0, 32'd0, 32'd0, 0, 32'd5, "sw rl 0");
    access(2, 0, 32'd4, 32'd0, 0, 32'd7, "sw rl 4");

    access(2, 1, 32'd2, 32'd9, 1, 32'd0, "st misalign");
    access(2, 0, 32'd0, 32'd0, 0, 32'd5, "ld 0 after fault");
    access(2, 0, 32'd4096, 32'd0, 1, 32'd0, "ld 4096");
    access(2, 0, 32'd1, 32'd0, 1, 32'd0, "ld misalign");
    access(2, 0, 32'hFFFF_FFFC, 32'd0, 1, 32'd0, "ld top");
    access(2, 1, 32'd4092, 32'h0000_ABCD, 0, 32'd0, "st last");
    access(2, 0, 32'd4092, 32'd0, 0, 32'h0000_ABCD, "ld last");

    access(2, 1, 32'd8, 32'd3, 0, 32'd0, "st 3@8");
    access(2, 1, 32'd12, 32'h77, 0, 32'd0, "st 77@12");
    st_addr.push_back(32'd8); st_exp.push_back(32'd3);
    st_addr.push_back(32'd8); st_exp.push_back(32'd3);
    st_addr.push_back(32'd8); st_exp.push_back(32'd3);
    stream(2, "hold req");

    @(negedge clock);
    set_bus(2, 1'b1, 1'b1, 32'd8, 32'd11);
    @(negedge clock);
    set_bus(2, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("mid-store busy", 32'(b2.ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst ready", 32'(b2.ready), 32'd1);
    chk("mid rst ack", 32'(b2.ack), 32'd0);
    chk("mid rst busy", 32'(b2.busy), 32'd0);
    @(negedge clock);
    chk("mid rst ack2", 32'(b2.ack), 32'd0);
    rst_n = 1'b1;
    access(2, 0, 32'd8, 32'd0, 0, 32'd3, "ld 8 after rst");

    access(0, 1, 32'd0, 32'h11, 0, 32'd0, "w0 st 0");
    access(0, 1, 32'd4, 32'h22, 0, 32'd0, "w0 st 4");
    st_addr.push_back(32'd0); st_exp.push_back(32'h11);
    st_addr.push_back(32'd4); st_exp.push_back(32'h22);
    stream(0, "w0 b2b");
    access(0, 0, 32'd4096, 32'd0, 1, 32'd0, "w0 ld 4096");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
